// File: rtl/cpu_pkg.sv
// Shared CPU control constants: slot count, counter width and the slot index
// names the control unit uses when decoding micro-operation strobes.
package cpu_pkg;
    localparam int NSTATES = 6;
    localparam int CW      = 3;

    localparam int T0 = 0;
    localparam int T1 = 1;
    localparam int T2 = 2;
    localparam int T3 = 3;
    localparam int T4 = 4;
    localparam int T5 = 5;
endpackage

// File: rtl/time_sequencer_if.sv
// Time-slot bus from the sequencer to the control-unit strobe decode.
interface time_sequencer_if #(
    parameter int NSTATES = cpu_pkg::NSTATES
);
    logic [NSTATES-1:0] t;

    modport master (output t);
    modport slave  (input  t);
endinterface

// File: rtl/time_sequencer_onehot_decoder.sv
// Maps the slot counter to a one-hot slot bus; out-of-range (or unknown)
// counts decode to all zeros.
module onehot_decoder #(
    parameter int CW      = 3,
    parameter int NSTATES = 6
) (
    input  logic [CW-1:0]      cnt,
    output logic [NSTATES-1:0] t
);
    always_comb begin
        t = '0;
        for (int k = 0; k < NSTATES; k++) begin
            if (cnt == CW'(k)) t[k] = 1'b1;
        end
    end
endmodule

// File: rtl/time_sequencer.sv
// Free-running T0..T(N-1) timing-state generator. The control unit terminates
// an instruction by pulsing reset, which may be derived from t itself.
module time_sequencer #(
    parameter int NSTATES = cpu_pkg::NSTATES,
    parameter int CW      = cpu_pkg::CW
) (
    input  logic              clock,
    input  logic              reset,
    time_sequencer_if.master  bus
);
    import cpu_pkg::*;

    logic [CW-1:0] cnt;

    // The else branch also catches illegal and unknown counts, so any bad
    // value is flushed back to T0 on the next edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cnt <= CW'(T0);
        else if (cnt < CW'(NSTATES-1))
            cnt <= cnt + 1'b1;
        else
            cnt <= CW'(T0);
    end

    onehot_decoder #(
        .CW      (CW),
        .NSTATES (NSTATES)
    ) u_dec (
        .cnt (cnt),
        .t   (bus.t)
    );
endmodule

// File: tb/tb_time_sequencer.sv
// Directed bench for time_sequencer with a slot-index reference model.
module tb_time_sequencer;
    logic clk_raw = 1'b0;
    logic clk_en;
    logic clock;
    logic rst_drv;
    logic fb;
    logic reset;
    logic chk_en;
    int   checks = 0;
    int   errors = 0;
    int   slot   = 0;

    time_sequencer_if tif ();

    assign clock = clk_raw & clk_en;
    assign reset = rst_drv | (fb & tif.t[4]);

    time_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (tif)
    );

    logic [2:0] dcnt;
    logic [5:0] dt;
    onehot_decoder #(.CW(3), .NSTATES(6)) udec (.cnt(dcnt), .t(dt));

    always #5 clk_raw = ~clk_raw;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Reference: slot index advances mod 6 per clock, any illegal index goes to
    // 0, reset forces 0, and with feedback enabled reaching slot 4 ends at 0.
    always @(posedge clock or posedge reset) begin
        if (reset) slot = 0;
        else begin
            slot = (slot < 5) ? slot + 1 : 0;
            if (fb && slot == 4) slot = 0;
        end
    end

    always @(negedge clk_raw) begin
        if (chk_en) chk("model", {26'd0, tif.t}, (slot < 6) ? (32'd1 << slot) : 32'd0);
    end

    task automatic find_slot(input logic [5:0] want, input string name);
        int n = 0;
        while (tif.t !== want && n < 12) begin
            @(posedge clk_raw); #1;
            n++;
        end
        chk(name, {26'd0, tif.t}, {26'd0, want});
    endtask

    logic [5:0] hist [20];
    logic [5:0] seq_exp [6];
    logic [5:0] fb_exp [5];

    initial begin
        rst_drv = 1'b0; fb = 1'b0; clk_en = 1'b1; chk_en = 1'b0; dcnt = '0;
        seq_exp = '{6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000, 6'b000001};
        fb_exp  = '{6'b000010, 6'b000100, 6'b001000, 6'b000001, 6'b000010};

        // reset visible without a clock edge, then held across two edges
        #1 rst_drv = 1'b1;
        #1 chk("rst_t0", {26'd0, tif.t}, 32'h1);
        chk_en = 1'b1;
        repeat (2) begin
            @(posedge clk_raw); #1;
            chk("rst_hold", {26'd0, tif.t}, 32'h1);
        end
        #1 rst_drv = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_raw); #1;
            chk("seq", {26'd0, tif.t}, {26'd0, seq_exp[i]});
        end

        // free run: one-hot, period 6, T5 -> T0 wrap
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_raw); #1;
            hist[i] = tif.t;
            chk("onehot", $countones(hist[i]), 32'd1);
            if (i >= 6) chk("period", {26'd0, hist[i]}, {26'd0, hist[i-6]});
            if (i > 0 && hist[i-1] == 6'b100000) chk("wrap", {26'd0, hist[i]}, 32'h1);
        end

        // asynchronous reset mid-cycle at T3
        find_slot(6'b001000, "find_t3");
        #1 rst_drv = 1'b1;
        #1 chk("mid_rst", {26'd0, tif.t}, 32'h1);
        #1 rst_drv = 1'b0;
        @(posedge clk_raw); #1;
        chk("after_mid_rst", {26'd0, tif.t}, 32'h2);

        // mov-style termination: reset = t[4] fed back combinationally
        #1 rst_drv = 1'b1; fb = 1'b1;
        @(posedge clk_raw); #1;
        chk("fb_t0", {26'd0, tif.t}, 32'h1);
        #1 rst_drv = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_raw); #1;
            chk("fb_seq", {26'd0, tif.t}, {26'd0, fb_exp[i]});
        end
        #1 fb = 1'b0;

        // illegal count deposited into the state register
        @(posedge clk_raw); #2;
        dut.cnt <= 3'd7;
        slot = 7;
        #1 chk("illegal_zero", {26'd0, tif.t}, 32'h0);
        @(posedge clk_raw); #1;
        chk("illegal_recover", {26'd0, tif.t}, 32'h1);

        // decoder on its own over the full count range
        for (int k = 0; k < 8; k++) begin
            dcnt = 3'(k);
            #1 chk("dec", {26'd0, dt}, (k < 6) ? (32'd1 << k) : 32'd0);
        end

        // clock gated off at T2
        find_slot(6'b000100, "find_t2");
        @(negedge clk_raw); #1 clk_en = 1'b0;
        repeat (10) begin
            @(posedge clk_raw); #1;
            chk("gated_hold", {26'd0, tif.t}, 32'h4);
        end
        @(negedge clk_raw); #1 clk_en = 1'b1;
        @(posedge clk_raw); #1;
        chk("gated_resume", {26'd0, tif.t}, 32'h8);

        @(negedge clk_raw); #1 chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout at %0t: got running expected finished", $time);
        $fatal(1, "timeout");
    end
endmodule
